// File: rtl/rs_multi_issue.sv
// Superscalar reservation station: age-matrix ordered entries, CDB wakeup with
// dispatch bypass, and one oldest-ready issue per FU type per cycle.
module rs_multi_issue #(
    parameter int RS_SIZE    = 8,
    parameter int DISPATCH_W = 2,
    parameter int CDB_W      = 2,
    parameter int FU_TYPES   = 4,
    parameter int PR_W       = 6,
    parameter int PAYLOAD_W  = 32
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   enable,
    input  logic                                   flush,
    input  logic [DISPATCH_W-1:0]                  dispatch_valid,
    input  logic [DISPATCH_W*$clog2(FU_TYPES)-1:0] dispatch_fu,
    input  logic [DISPATCH_W*(PR_W+1)-1:0]         dispatch_dest,
    input  logic [DISPATCH_W*(PR_W+1)-1:0]         dispatch_src1,
    input  logic [DISPATCH_W*(PR_W+1)-1:0]         dispatch_src2,
    input  logic [DISPATCH_W*PAYLOAD_W-1:0]        dispatch_payload,
    output logic [DISPATCH_W-1:0]                  dispatch_accept,
    input  logic [CDB_W-1:0]                       cdb_valid,
    input  logic [CDB_W*PR_W-1:0]                  cdb_tag,
    input  logic [FU_TYPES-1:0]                    fu_busy,
    output logic [FU_TYPES-1:0]                    issue_valid,
    output logic [FU_TYPES*(PR_W+1)-1:0]           issue_dest,
    output logic [FU_TYPES*(PR_W+1)-1:0]           issue_src1,
    output logic [FU_TYPES*(PR_W+1)-1:0]           issue_src2,
    output logic [FU_TYPES*PAYLOAD_W-1:0]          issue_payload,
    output logic [$clog2(RS_SIZE+1)-1:0]           free_slots,
    output logic                                   rs_full
);
    localparam int FU_W  = $clog2(FU_TYPES);
    localparam int TAG_W = PR_W + 1;
    localparam int CNT_W = $clog2(RS_SIZE + 1);

    logic [RS_SIZE-1:0]   busy_q, busy_d;
    logic [FU_W-1:0]      fu_q      [RS_SIZE];
    logic [FU_W-1:0]      fu_d      [RS_SIZE];
    logic [TAG_W-1:0]     dest_q    [RS_SIZE];
    logic [TAG_W-1:0]     dest_d    [RS_SIZE];
    logic [TAG_W-1:0]     src1_q    [RS_SIZE];
    logic [TAG_W-1:0]     src1_d    [RS_SIZE];
    logic [TAG_W-1:0]     src2_q    [RS_SIZE];
    logic [TAG_W-1:0]     src2_d    [RS_SIZE];
    logic [PAYLOAD_W-1:0] payload_q [RS_SIZE];
    logic [PAYLOAD_W-1:0] payload_d [RS_SIZE];
    // older_q[i][j] set means entry i was dispatched before entry j
    logic [RS_SIZE-1:0]   older_q   [RS_SIZE];
    logic [RS_SIZE-1:0]   older_d   [RS_SIZE];

    logic [FU_TYPES-1:0]           iv_q, iv_d;
    logic [FU_TYPES*TAG_W-1:0]     idest_q, idest_d;
    logic [FU_TYPES*TAG_W-1:0]     is1_q, is1_d;
    logic [FU_TYPES*TAG_W-1:0]     is2_q, is2_d;
    logic [FU_TYPES*PAYLOAD_W-1:0] ipay_q, ipay_d;

    logic [RS_SIZE-1:0] ready;
    logic [RS_SIZE-1:0] cand;
    logic [RS_SIZE-1:0] taken;
    logic               oldest;
    int                 free_cnt;
    int                 rank;
    int                 slot;

    function automatic logic [TAG_W-1:0] wake(input logic [TAG_W-1:0]      tag,
                                              input logic [CDB_W-1:0]      vld,
                                              input logic [CDB_W*PR_W-1:0] tags);
        logic [TAG_W-1:0] res;
        res = tag;
        for (int c = 0; c < CDB_W; c++) begin
            if (vld[c] && (tags[c*PR_W +: PR_W] == tag[PR_W-1:0])) res[PR_W] = 1'b1;
        end
        return res;
    endfunction

    always_comb begin
        free_cnt = 0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (!busy_q[i]) free_cnt = free_cnt + 1;
        end
    end

    assign free_slots = CNT_W'(free_cnt);
    assign rs_full    = (free_cnt < DISPATCH_W);

    always_comb begin
        busy_d          = busy_q;
        fu_d            = fu_q;
        dest_d          = dest_q;
        payload_d       = payload_q;
        older_d         = older_q;
        iv_d            = '0;
        idest_d         = idest_q;
        is1_d           = is1_q;
        is2_d           = is2_q;
        ipay_d          = ipay_q;
        dispatch_accept = '0;
        taken           = busy_q;
        cand            = '0;
        oldest          = 1'b0;
        rank            = 0;
        slot            = 0;

        for (int i = 0; i < RS_SIZE; i++) begin
            ready[i]  = busy_q[i] & src1_q[i][PR_W] & src2_q[i][PR_W];
            src1_d[i] = wake(src1_q[i], cdb_valid, cdb_tag);
            src2_d[i] = wake(src2_q[i], cdb_valid, cdb_tag);
        end

        // Selection uses pre-edge state, so a just-woken entry waits one cycle.
        for (int t = 0; t < FU_TYPES; t++) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                cand[i] = ready[i] && (fu_q[i] == FU_W'(t));
            end
            for (int i = 0; i < RS_SIZE; i++) begin
                oldest = cand[i];
                for (int j = 0; j < RS_SIZE; j++) begin
                    if (j != i && cand[j] && older_q[j][i]) oldest = 1'b0;
                end
                if (oldest && enable && !flush && !fu_busy[t]) begin
                    iv_d[t]                       = 1'b1;
                    idest_d[t*TAG_W +: TAG_W]     = dest_q[i];
                    is1_d[t*TAG_W +: TAG_W]       = src1_q[i];
                    is2_d[t*TAG_W +: TAG_W]       = src2_q[i];
                    ipay_d[t*PAYLOAD_W +: PAYLOAD_W] = payload_q[i];
                    busy_d[i]                     = 1'b0;
                end
            end
        end

        // Slots freed by this edge's issue stay unavailable: taken starts from busy_q.
        for (int l = 0; l < DISPATCH_W; l++) begin
            if (dispatch_valid[l]) begin
                if (enable && !flush && rank < free_cnt) begin
                    dispatch_accept[l] = 1'b1;
                    slot = 0;
                    for (int i = RS_SIZE - 1; i >= 0; i--) begin
                        if (!taken[i]) slot = i;
                    end
                    taken[slot]     = 1'b1;
                    busy_d[slot]    = 1'b1;
                    fu_d[slot]      = dispatch_fu[l*FU_W +: FU_W];
                    dest_d[slot]    = dispatch_dest[l*TAG_W +: TAG_W];
                    src1_d[slot]    = wake(dispatch_src1[l*TAG_W +: TAG_W], cdb_valid, cdb_tag);
                    src2_d[slot]    = wake(dispatch_src2[l*TAG_W +: TAG_W], cdb_valid, cdb_tag);
                    payload_d[slot] = dispatch_payload[l*PAYLOAD_W +: PAYLOAD_W];
                    for (int k = 0; k < RS_SIZE; k++) begin
                        older_d[k][slot] = (k != slot);
                        older_d[slot][k] = 1'b0;
                    end
                end
                rank = rank + 1;
            end
        end

        if (flush) busy_d = '0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy_q  <= '0;
            iv_q    <= '0;
            idest_q <= '0;
            is1_q   <= '0;
            is2_q   <= '0;
            ipay_q  <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                fu_q[i]      <= '0;
                dest_q[i]    <= '0;
                src1_q[i]    <= '0;
                src2_q[i]    <= '0;
                payload_q[i] <= '0;
                older_q[i]   <= '0;
            end
        end else begin
            busy_q    <= busy_d;
            fu_q      <= fu_d;
            dest_q    <= dest_d;
            src1_q    <= src1_d;
            src2_q    <= src2_d;
            payload_q <= payload_d;
            older_q   <= older_d;
            iv_q      <= iv_d;
            idest_q   <= idest_d;
            is1_q     <= is1_d;
            is2_q     <= is2_d;
            ipay_q    <= ipay_d;
        end
    end

    assign issue_valid   = iv_q;
    assign issue_dest    = idest_q;
    assign issue_src1    = is1_q;
    assign issue_src2    = is2_q;
    assign issue_payload = ipay_q;

endmodule

// File: tb/tb_rs_multi_issue.sv
// Directed vector table plus randomized traffic for rs_multi_issue, checked
// against a sequence-number based reference model of the station.
module tb_rs_multi_issue;
    localparam int RS = 8;
    localparam int DW = 2;
    localparam int CW = 2;
    localparam int FT = 4;
    localparam int PW = 6;
    localparam int PL = 32;
    localparam int TW = 7;

    logic             clock, reset, enable, flush;
    logic [DW-1:0]    dispatch_valid;
    logic [DW*2-1:0]  dispatch_fu;
    logic [DW*TW-1:0] dispatch_dest, dispatch_src1, dispatch_src2;
    logic [DW*PL-1:0] dispatch_payload;
    logic [DW-1:0]    dispatch_accept;
    logic [CW-1:0]    cdb_valid;
    logic [CW*PW-1:0] cdb_tag;
    logic [FT-1:0]    fu_busy, issue_valid;
    logic [FT*TW-1:0] issue_dest, issue_src1, issue_src2;
    logic [FT*PL-1:0] issue_payload;
    logic [3:0]       free_slots;
    logic             rs_full;

    rs_multi_issue dut (
        .clock(clock), .reset(reset), .enable(enable), .flush(flush),
        .dispatch_valid(dispatch_valid), .dispatch_fu(dispatch_fu),
        .dispatch_dest(dispatch_dest), .dispatch_src1(dispatch_src1),
        .dispatch_src2(dispatch_src2), .dispatch_payload(dispatch_payload),
        .dispatch_accept(dispatch_accept), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .fu_busy(fu_busy), .issue_valid(issue_valid), .issue_dest(issue_dest),
        .issue_src1(issue_src1), .issue_src2(issue_src2), .issue_payload(issue_payload),
        .free_slots(free_slots), .rs_full(rs_full)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks;
    int errors;

    // Reference model: entries carry a monotonically increasing dispatch number.
    logic        mb   [RS];
    logic [1:0]  mfu  [RS];
    logic [6:0]  md   [RS];
    logic [6:0]  ms1  [RS];
    logic [6:0]  ms2  [RS];
    logic [31:0] mp   [RS];
    int          mseq [RS];
    int          seq_ctr;
    logic [FT-1:0]    ev;
    logic [FT*TW-1:0] edst, es1, es2;
    logic [FT*PL-1:0] epay;

    typedef struct {
        int en, fl, v;
        int f0, a0, b0;
        int f1, a1, b1;
        int cv, c0, c1;
        int fb;
        int xacc, xfree, xfull, xiv;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic mreset();
        for (int i = 0; i < RS; i++) begin
            mb[i] = 1'b0;
            mseq[i] = 0;
        end
        seq_ctr = 0;
        ev = '0;
        edst = '0;
        es1 = '0;
        es2 = '0;
        epay = '0;
    endtask

    function automatic int mfree();
        int n;
        n = 0;
        for (int i = 0; i < RS; i++) if (!mb[i]) n++;
        return n;
    endfunction

    function automatic logic [1:0] macc();
        logic [1:0] a;
        int n;
        a = '0;
        n = 0;
        for (int l = 0; l < DW; l++) begin
            if (dispatch_valid[l]) begin
                if (enable && !flush && n < mfree()) a[l] = 1'b1;
                n++;
            end
        end
        return a;
    endfunction

    function automatic logic [6:0] mwake(input logic [6:0] tg);
        logic [6:0] r;
        r = tg;
        for (int c = 0; c < CW; c++)
            if (cdb_valid[c] && cdb_tag[c*PW +: PW] == tg[5:0]) r[6] = 1'b1;
        return r;
    endfunction

    task automatic mstep();
        logic [1:0] a;
        logic nb [RS];
        logic tk [RS];
        int best;
        int s;
        a = macc();
        if (flush) begin
            for (int i = 0; i < RS; i++) mb[i] = 1'b0;
            ev = '0;
            return;
        end
        nb = mb;
        ev = '0;
        for (int t = 0; t < FT; t++) begin
            if (enable && !fu_busy[t]) begin
                best = -1;
                for (int i = 0; i < RS; i++) begin
                    if (mb[i] && ms1[i][6] && ms2[i][6] && mfu[i] == 2'(t)) begin
                        if (best < 0) best = i;
                        else if (mseq[i] < mseq[best]) best = i;
                    end
                end
                if (best >= 0) begin
                    ev[t] = 1'b1;
                    edst[t*TW +: TW] = md[best];
                    es1[t*TW +: TW]  = ms1[best];
                    es2[t*TW +: TW]  = ms2[best];
                    epay[t*PL +: PL] = mp[best];
                    nb[best] = 1'b0;
                end
            end
        end
        for (int i = 0; i < RS; i++) begin
            ms1[i] = mwake(ms1[i]);
            ms2[i] = mwake(ms2[i]);
            tk[i]  = mb[i];
        end
        for (int l = 0; l < DW; l++) begin
            if (a[l]) begin
                s = 0;
                for (int i = 0; i < RS; i++) if (!tk[i]) begin s = i; break; end
                tk[s] = 1'b1;
                nb[s] = 1'b1;
                mfu[s] = dispatch_fu[l*2 +: 2];
                md[s]  = dispatch_dest[l*TW +: TW];
                ms1[s] = mwake(dispatch_src1[l*TW +: TW]);
                ms2[s] = mwake(dispatch_src2[l*TW +: TW]);
                mp[s]  = dispatch_payload[l*PL +: PL];
                mseq[s] = seq_ctr;
                seq_ctr++;
            end
        end
        mb = nb;
    endtask

    task automatic set_lane(input int l, input logic v, input logic [1:0] f, input logic [6:0] d,
                            input logic [6:0] s1, input logic [6:0] s2, input logic [31:0] p);
        dispatch_valid[l]           = v;
        dispatch_fu[l*2 +: 2]       = f;
        dispatch_dest[l*TW +: TW]   = d;
        dispatch_src1[l*TW +: TW]   = s1;
        dispatch_src2[l*TW +: TW]   = s2;
        dispatch_payload[l*PL +: PL] = p;
    endtask

    task automatic idle();
        enable = 1'b1;
        flush = 1'b0;
        dispatch_valid = '0;
        dispatch_fu = '0;
        dispatch_dest = '0;
        dispatch_src1 = '0;
        dispatch_src2 = '0;
        dispatch_payload = '0;
        cdb_valid = '0;
        cdb_tag = '0;
        fu_busy = '0;
    endtask

    // Called at posedge+1 with inputs already driven.
    task automatic step_pre();
        #1;
        chk("dispatch_accept", 128'(dispatch_accept), 128'(macc()));
        chk("free_slots", 128'(free_slots), 128'(mfree()));
        chk("rs_full", 128'(rs_full), 128'(mfree() < DW));
        mstep();
    endtask

    task automatic step_post();
        @(posedge clock);
        #1;
        chk("issue_valid", 128'(issue_valid), 128'(ev));
        chk("issue_dest", 128'(issue_dest), 128'(edst));
        chk("issue_src1", 128'(issue_src1), 128'(es1));
        chk("issue_src2", 128'(issue_src2), 128'(es2));
        chk("issue_payload", 128'(issue_payload), 128'(epay));
    endtask

    task automatic step();
        step_pre();
        step_post();
    endtask

    task automatic row(input int en, input int fl, input int v,
                       input int f0, input int a0, input int b0,
                       input int f1, input int a1, input int b1,
                       input int cv, input int c0, input int c1, input int fb,
                       input int xacc, input int xfree, input int xfull, input int xiv);
        vec_t r;
        r.en = en; r.fl = fl; r.v = v;
        r.f0 = f0; r.a0 = a0; r.b0 = b0;
        r.f1 = f1; r.a1 = a1; r.b1 = b1;
        r.cv = cv; r.c0 = c0; r.c1 = c1; r.fb = fb;
        r.xacc = xacc; r.xfree = xfree; r.xfull = xfull; r.xiv = xiv;
        tbl.push_back(r);
    endtask

    function automatic logic [6:0] rtag();
        if ($urandom_range(0, 1) == 1) return {1'b1, 6'($urandom)};
        return {1'b0, 6'($urandom_range(0, 15))};
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        mreset();
        idle();
        reset = 1'b0;

        // en fl v | lane0 fu s1 s2 | lane1 fu s1 s2 | cv c0 c1 fb | acc free full iv
        row(1,0,1, 0,'h05,'h7F, 0,'h7F,'h7F, 0,0,0,0, 1,8,0,0);
        row(1,0,0, 0,0,0,       0,0,0,       0,0,0,0, 0,7,0,0);
        row(1,0,0, 0,0,0,       0,0,0,       0,0,0,0, 0,7,0,0);
        row(1,0,0, 0,0,0,       0,0,0,       0,0,0,0, 0,7,0,0);
        row(1,0,0, 0,0,0,       0,0,0,       2,0,5,0, 0,7,0,0);
        row(1,0,0, 0,0,0,       0,0,0,       0,0,0,0, 0,7,0,1);
        row(1,0,1, 3,'h09,'h7F, 0,0,0,       1,9,0,0, 1,8,0,0);
        row(1,0,0, 0,0,0,       0,0,0,       0,0,0,0, 0,7,0,8);
        row(1,0,3, 0,'h11,'h7F, 0,'h12,'h7F, 0,0,0,0, 3,8,0,0);
        row(1,0,3, 0,'h13,'h7F, 0,'h14,'h7F, 0,0,0,0, 3,6,0,0);
        row(1,0,3, 0,'h15,'h7F, 0,'h16,'h7F, 0,0,0,0, 3,4,0,0);
        row(1,0,1, 0,'h17,'h7F, 0,0,0,       0,0,0,0, 1,2,0,0);
        row(1,0,3, 0,'h18,'h7F, 0,'h19,'h7F, 0,0,0,0, 1,1,1,0);
        row(1,0,3, 0,'h1A,'h7F, 0,'h1B,'h7F, 0,0,0,0, 0,0,1,0);
        row(1,1,3, 0,'h7F,'h7F, 0,'h7F,'h7F, 0,0,0,0, 0,0,1,0);
        row(1,0,0, 0,0,0,       0,0,0,       0,0,0,0, 0,8,0,0);
        row(1,0,3, 2,'h40,'h7F, 2,'h41,'h7F, 0,0,0,4, 3,8,0,0);
        row(1,0,3, 2,'h42,'h7F, 0,'h7F,'h7F, 0,0,0,4, 3,6,0,0);
        row(1,0,0, 0,0,0,       0,0,0,       0,0,0,4, 0,4,0,1);
        row(1,0,1, 0,'h7F,'h7F, 0,0,0,       0,0,0,0, 1,5,0,4);
        row(1,0,0, 0,0,0,       0,0,0,       0,0,0,0, 0,5,0,5);
        row(1,0,0, 0,0,0,       0,0,0,       0,0,0,0, 0,7,0,4);
        row(1,0,3, 0,'h7F,'h7F, 2,'h20,'h7F, 0,0,0,0, 3,8,0,0);
        row(0,0,3, 0,'h7F,'h7F, 0,'h7F,'h7F, 1,'h20,0,0, 0,6,0,0);
        row(0,0,0, 0,0,0,       0,0,0,       0,0,0,0, 0,6,0,0);
        row(1,0,0, 0,0,0,       0,0,0,       0,0,0,0, 0,6,0,5);
        row(1,0,3, 0,'h7F,'h7F, 0,'h7F,'h7F, 0,0,0,0, 3,8,0,0);
        row(1,1,3, 0,'h7F,'h7F, 0,'h7F,'h7F, 0,0,0,0, 0,6,0,0);
        row(1,0,0, 0,0,0,       0,0,0,       0,0,0,0, 0,8,0,0);

        // Reset state, then mid-run asynchronous reset with entries busy.
        @(posedge clock);
        #1;
        chk("rst_issue_valid", 128'(issue_valid), 128'(0));
        chk("rst_free_slots", 128'(free_slots), 128'(8));
        chk("rst_rs_full", 128'(rs_full), 128'(0));
        chk("rst_issue_dest", 128'(issue_dest), 128'(0));
        reset = 1'b1;
        set_lane(0, 1'b1, 2'd0, 7'h10, 7'h01, 7'h7F, 32'h1111);
        set_lane(1, 1'b1, 2'd2, 7'h11, 7'h02, 7'h7F, 32'h2222);
        step();
        set_lane(0, 1'b1, 2'd1, 7'h12, 7'h03, 7'h7F, 32'h3333);
        set_lane(1, 1'b1, 2'd0, 7'h13, 7'h7F, 7'h7F, 32'h4444);
        step();
        idle();
        step();
        chk("pre_rst_issue_valid", 128'(issue_valid), 128'(1));
        chk("pre_rst_free_slots", 128'(free_slots), 128'(5));
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_issue_valid", 128'(issue_valid), 128'(0));
        chk("async_rst_free_slots", 128'(free_slots), 128'(8));
        chk("async_rst_rs_full", 128'(rs_full), 128'(0));
        chk("async_rst_issue_payload", 128'(issue_payload), 128'(0));
        chk("async_rst_issue_src1", 128'(issue_src1), 128'(0));
        mreset();
        reset = 1'b1;
        set_lane(0, 1'b1, 2'd1, 7'd3, 7'h41, 7'h42, 32'hBEEF);
        step();
        idle();
        step();
        chk("mult_issue_valid", 128'(issue_valid), 128'(4'b0010));
        chk("mult_issue_dest", 128'(issue_dest[1*TW +: TW]), 128'(3));
        step();

        // Directed table.
        for (int r = 0; r < tbl.size(); r++) begin
            idle();
            enable = 1'(tbl[r].en);
            flush  = 1'(tbl[r].fl);
            set_lane(0, 1'(tbl[r].v), 2'(tbl[r].f0), 7'(r*2), 7'(tbl[r].a0), 7'(tbl[r].b0),
                     32'hC0DE0000 + 32'(r*2));
            set_lane(1, 1'(tbl[r].v >> 1), 2'(tbl[r].f1), 7'(r*2+1), 7'(tbl[r].a1), 7'(tbl[r].b1),
                     32'hC0DE0000 + 32'(r*2+1));
            cdb_valid = 2'(tbl[r].cv);
            cdb_tag   = {6'(tbl[r].c1), 6'(tbl[r].c0)};
            fu_busy   = 4'(tbl[r].fb);
            step_pre();
            chk($sformatf("tbl%0d_accept", r), 128'(dispatch_accept), 128'(tbl[r].xacc));
            chk($sformatf("tbl%0d_free", r), 128'(free_slots), 128'(tbl[r].xfree));
            chk($sformatf("tbl%0d_full", r), 128'(rs_full), 128'(tbl[r].xfull));
            step_post();
            chk($sformatf("tbl%0d_issue_valid", r), 128'(issue_valid), 128'(tbl[r].xiv));
        end
        chk("wakeup_src1", 128'(issue_src1[0 +: TW]), 128'(7'h7F));

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            enable = ($urandom_range(0, 9) != 0);
            flush  = ($urandom_range(0, 39) == 0);
            for (int l = 0; l < DW; l++)
                set_lane(l, 1'($urandom), 2'($urandom), 7'($urandom), rtag(), rtag(), $urandom);
            cdb_valid = 2'($urandom);
            cdb_tag   = {6'($urandom_range(0, 15)), 6'($urandom_range(0, 15))};
            fu_busy   = 4'($urandom) & 4'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rs_multi_issue.md
Name: rs_multi_issue

Overview:
- Parametrised superscalar reservation station for the R10K-style out-of-order core.
- Sits between dispatch (map table / free list) and the functional units.
- Accepts up to DISPATCH_W instructions per cycle and wakes operands from CDB_W CDB broadcasts.
- Issues at most one instruction per FU type per cycle, oldest-ready first, with per-FU back-pressure and a full-table flush.

Parameters:
- RS_SIZE, 8: number of entries.
- DISPATCH_W, 2: dispatch lanes per cycle.
- CDB_W, 2: CDB broadcast ports.
- FU_TYPES, 4: issue ports, one per FU type (0=ALU, 1=MULT, 2=LD, 3=ST).
- PR_W, 6: physical register index width. Tag = PR_W+1 bits; the MSB is the ready flag. The all-ones tag means "no operand" and is therefore ready.
- PAYLOAD_W, 32: opaque decoded-instruction payload width.

Ports:
- clock  in  1  system clock, posedge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- enable  in  1  1 = dispatch and issue allowed.
- flush  in  1  synchronous squash of all entries.
- dispatch_valid  in  DISPATCH_W  per-lane valid.
- dispatch_fu  in  DISPATCH_W*$clog2(FU_TYPES)  FU type per lane.
- dispatch_dest  in  DISPATCH_W*(PR_W+1)  destination tag T.
- dispatch_src1  in  DISPATCH_W*(PR_W+1)  source tag T1.
- dispatch_src2  in  DISPATCH_W*(PR_W+1)  source tag T2.
- dispatch_payload  in  DISPATCH_W*PAYLOAD_W  decoded instruction.
- dispatch_accept  out  DISPATCH_W  lane written into the table this edge (combinational).
- cdb_valid  in  CDB_W  broadcast valid.
- cdb_tag  in  CDB_W*PR_W  broadcast physical register.
- fu_busy  in  FU_TYPES  1 = FU type cannot take an issue this edge.
- issue_valid  out  FU_TYPES  registered issue pulse.
- issue_dest  out  FU_TYPES*(PR_W+1)  registered issue field.
- issue_src1  out  FU_TYPES*(PR_W+1)  registered issue field.
- issue_src2  out  FU_TYPES*(PR_W+1)  registered issue field.
- issue_payload  out  FU_TYPES*PAYLOAD_W  registered issue field.
- free_slots  out  $clog2(RS_SIZE+1)  count of non-busy entries.
- rs_full  out  1  free_slots < DISPATCH_W.

Behaviour:
- Entry fields: busy, fu, dest, src1, src2, payload, and relative age.
- Entry ready: busy and both source MSBs are 1.

Reset (reset=0):
- All busy=0.
- issue_valid=0 and all issue fields 0.
- free_slots=RS_SIZE; rs_full=0.
- Takes effect immediately; no partial state survives.

Dispatch:
- F = free_slots at the start of the cycle.
- Valid lanes are ranked in lane order. Lane i is accepted iff valid[i], enable=1, flush=0, and its rank among valid lanes < F.
- Accepted lanes fill the lowest-indexed free entries, in lane order.
- Entries freed by an issue on the same edge are not reusable until the next cycle.

Wakeup, every edge, independent of enable:
- Any stored or incoming source whose low PR_W bits equal a valid cdb_tag gets its MSB set.
- Incoming dispatch sources are bypassed this way, so no broadcast is lost.
- Duplicate CDB tags are harmless.

Issue, at the edge, per FU type t:
- Condition: enable=1, flush=0, fu_busy[t]=0.
- Select the oldest entry that is ready, based on state before this edge, with fu==t.
- Copy it to issue register t, set issue_valid[t]=1, clear its busy bit.
- Otherwise issue_valid[t]=0 and the issue fields hold their previous values.

Latency:
- Dispatch at edge N → earliest issue_valid after edge N+1.
- CDB wakeup at edge N → earliest issue after edge N+1.

Age:
- An entry dispatched earlier is older.
- Among entries from the same cycle, the lower lane is older.
- Age must stay correct across arbitrary slot reuse; no wrap artefacts.

enable=0:
- No dispatch (dispatch_accept=0), no issue (issue_valid=0).
- Table and wakeup still update.

flush=1:
- At the edge, all busy=0 and issue_valid=0.
- Overrides dispatch, wakeup and issue in that cycle.

Outputs:
- free_slots, rs_full and dispatch_accept are combinational from registered state plus inputs.
- issue_* outputs are registered.

Test Plan:
1. Reset: hold reset=0 mid-run with 3 entries busy → immediately issue_valid=0, free_slots=8, rs_full=0. Release reset; dispatch lane0 MULT, T=3, T1=7'b1000001, T2=7'b1000010 → after the next edge issue_valid[1]=1, issue_dest=3.
2. Wakeup: dispatch ADD with T1=7'h05 (not ready), T2=7'h7F. No issue for 3 cycles. Drive cdb_valid[1]=1, cdb_tag=5 → issue_valid[0]=1 one edge later with issue_src1=7'h45.
3. Dispatch bypass: dispatch ST with T1=7'h09 while cdb_tag[0]=9 in the same cycle → the ST issues after the following edge.
4. Full and partial accept: fill 7 entries with unready ALU ops. Then valid=2'b11 → dispatch_accept=2'b01, free_slots=0, rs_full=1. Next cycle dispatch_accept=2'b00.
5. Age and back-pressure: three ready LDs dispatched in order A, B (same cycle, lanes 0/1), then C; fu_busy[2]=1 for 2 cycles → no LD issue. Release → issue order A, B, C on consecutive cycles. ALU issues continue unaffected.
6. Flush/enable: enable=0 with ready entries → issue_valid=0 and wakeup still recorded. flush=1 with simultaneous dispatch → dispatch_accept=0; after the edge free_slots=8 and issue_valid=0.
